// File: rtl/audio_mix_pkg.sv
// Shared widths, FSM states and the shift/clamp helper for the audio mix scheduler.
// Optional clip counter in the top is enabled by AUDIO_MIX_CLIP_COUNT_EN.
package audio_mix_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int ACC_W      = 28;
    localparam int PROD_W     = 25;
    localparam int OUT_SHIFT  = 7;
    localparam int UNITY_GAIN = 128;
    localparam int MAX_SRC    = 8;
    localparam int STEP_W     = 4;
    localparam int IDX_W      = 3;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        SAT,
        DONE
    } state_t;

    typedef struct packed {
        logic                clip;
        logic [SAMPLE_W-1:0] val;
    } sat_t;

    // Drop the Q1.7 gain fraction (floor) and clamp to the 16-bit sample range.
    function automatic sat_t sat_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        sat_t                    r;
        s = a >>> OUT_SHIFT;
        r.clip = 1'b1;
        if (s > SAT_MAX) begin
            r.val = 16'h7fff;
        end else if (s < SAT_MIN) begin
            r.val = 16'h8000;
        end else begin
            r.clip = 1'b0;
            r.val  = s[SAMPLE_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_mac.sv
// Signed 16 x unsigned-gain multiply feeding a registered 28-bit accumulator.
// Latency: acc updates one cycle after enable; no backpressure (driven every cycle by the scheduler).
// clear+enable together restarts the sum with the current product.
module audio_mac
    import audio_mix_pkg::*;
#(
    parameter int GAIN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [SAMPLE_W-1:0]     sample,
    input  logic [GAIN_W-1:0]       gain,
    output logic signed [ACC_W-1:0] acc
);

    localparam int P_W = SAMPLE_W + GAIN_W + 1;

    logic signed [P_W-1:0]   sample_ext;
    logic signed [P_W-1:0]   gain_ext;
    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    always_comb begin
        sample_ext = {{(GAIN_W + 1){sample[SAMPLE_W-1]}}, sample};
        gain_ext   = {{(SAMPLE_W + 1){1'b0}}, gain};
        // Low P_W bits of the extended product equal the exact signed product.
        prod       = sample_ext * gain_ext;
        prod_ext   = {{(ACC_W - P_W){prod[P_W-1]}}, prod};
        base       = clear ? '0 : acc_q;
        acc_d      = acc_q;
        if (enable) begin
            acc_d = base + prod_ext;
        end else if (clear) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/audio_mix_sched.sv
// Time-shares one MAC over NSRC stereo sources with per-source gain; optional clip_count via AUDIO_MIX_CLIP_COUNT_EN.
// Latency: next_sample at cycle 0 -> mix_valid at cycle 2*NSRC+2.
// Backpressure: none; next_sample while busy is dropped and raises sticky overrun.
module audio_mix_sched
    import audio_mix_pkg::*;
#(
    parameter int NSRC   = 2,
    parameter int GAIN_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     next_sample,
    input  logic [NSRC*SAMPLE_W-1:0] src_left,
    input  logic [NSRC*SAMPLE_W-1:0] src_right,
    input  logic [IDX_W-1:0]         gain_addr,
    input  logic [GAIN_W-1:0]        gain_wrdata,
    input  logic                     gain_write,
    input  logic                     master_mute,
    input  logic                     overrun_clr,
    output logic [SAMPLE_W-1:0]      mix_left,
    output logic [SAMPLE_W-1:0]      mix_right,
    output logic                     mix_valid,
    output logic                     busy,
    output logic                     overrun
`ifdef AUDIO_MIX_CLIP_COUNT_EN
    ,
    output logic [7:0]               clip_count
`endif
);

    localparam logic [STEP_W-1:0] STEP_RIGHT = STEP_W'(NSRC);
    localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(2 * NSRC - 1);

    state_t                     state_q, state_d;
    logic [STEP_W-1:0]          step_q, step_d;
    logic [GAIN_W-1:0]          gain_q [MAX_SRC];
    logic [GAIN_W-1:0]          gain_d [MAX_SRC];
    logic [GAIN_W-1:0]          gain_snap_q [MAX_SRC];
    logic [GAIN_W-1:0]          gain_snap_d [MAX_SRC];
    logic [NSRC*SAMPLE_W-1:0]   snap_l_q, snap_l_d;
    logic [NSRC*SAMPLE_W-1:0]   snap_r_q, snap_r_d;
    logic signed [ACC_W-1:0]    park_q, park_d;
    logic [SAMPLE_W-1:0]        mix_l_q, mix_l_d;
    logic [SAMPLE_W-1:0]        mix_r_q, mix_r_d;
    logic                       overrun_q, overrun_d;

    logic                       mac_clear;
    logic                       mac_en;
    logic [SAMPLE_W-1:0]        mac_sample;
    logic [GAIN_W-1:0]          mac_gain;
    logic signed [ACC_W-1:0]    mac_acc;
    logic                       is_left;
    logic [IDX_W-1:0]           src_idx;
    sat_t                       sat_l;
    sat_t                       sat_r;

    assign busy = (state_q != IDLE);

    // Steps 0..NSRC-1 walk the left channels, NSRC..2*NSRC-1 the right channels.
    always_comb begin
        is_left    = (step_q < STEP_RIGHT);
        src_idx    = is_left ? IDX_W'(step_q) : IDX_W'(step_q - STEP_RIGHT);
        mac_sample = is_left ? snap_l_q[SAMPLE_W*src_idx +: SAMPLE_W]
                             : snap_r_q[SAMPLE_W*src_idx +: SAMPLE_W];
        mac_gain   = gain_snap_q[src_idx];
        sat_l      = sat_shift(park_q);
        sat_r      = sat_shift(mac_acc);
    end

    always_comb begin
        gain_d = gain_q;
        if (gain_write && (32'(gain_addr) < NSRC)) begin
            gain_d[gain_addr] = gain_wrdata;
        end
        overrun_d = overrun_q;
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (next_sample && busy) begin
            overrun_d = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        snap_l_d    = snap_l_q;
        snap_r_d    = snap_r_q;
        gain_snap_d = gain_snap_q;
        park_d      = park_q;
        mix_l_d     = mix_l_q;
        mix_r_d     = mix_r_q;
        mac_clear   = 1'b0;
        mac_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (next_sample) begin
                    snap_l_d    = src_left;
                    snap_r_d    = src_right;
                    gain_snap_d = gain_q;
                    mac_clear   = 1'b1;
                    step_d      = '0;
                    state_d     = ACC;
                end
            end
            ACC: begin
                mac_en = 1'b1;
                // First right step: the accumulator holds the finished left sum.
                if (step_q == STEP_RIGHT) begin
                    park_d    = mac_acc;
                    mac_clear = 1'b1;
                end
                if (step_q == STEP_LAST) begin
                    state_d = SAT;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            SAT: begin
                mix_l_d = master_mute ? '0 : sat_l.val;
                mix_r_d = master_mute ? '0 : sat_r.val;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            step_q    <= '0;
            snap_l_q  <= '0;
            snap_r_q  <= '0;
            park_q    <= '0;
            mix_l_q   <= '0;
            mix_r_q   <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < MAX_SRC; i++) begin
                gain_q[i]      <= GAIN_W'(UNITY_GAIN);
                gain_snap_q[i] <= GAIN_W'(UNITY_GAIN);
            end
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            snap_l_q    <= snap_l_d;
            snap_r_q    <= snap_r_d;
            park_q      <= park_d;
            mix_l_q     <= mix_l_d;
            mix_r_q     <= mix_r_d;
            overrun_q   <= overrun_d;
            gain_q      <= gain_d;
            gain_snap_q <= gain_snap_d;
        end
    end

    audio_mac #(
        .GAIN_W (GAIN_W)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (mac_clear),
        .enable (mac_en),
        .sample (mac_sample),
        .gain   (mac_gain),
        .acc    (mac_acc)
    );

`ifdef AUDIO_MIX_CLIP_COUNT_EN
    logic [7:0] clip_cnt_q, clip_cnt_d;
    logic [8:0] clip_sum;

    // Clips are counted even when the output is muted.
    always_comb begin
        clip_cnt_d = overrun_clr ? 8'd0 : clip_cnt_q;
        clip_sum   = '0;
        if (state_q == SAT) begin
            clip_sum   = {1'b0, clip_cnt_d} + 9'(sat_l.clip) + 9'(sat_r.clip);
            clip_cnt_d = clip_sum[8] ? 8'hff : clip_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_cnt_q <= '0;
        end else begin
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign clip_count = clip_cnt_q;
`endif

    assign mix_left  = mix_l_q;
    assign mix_right = mix_r_q;
    assign mix_valid = (state_q == DONE);
    assign overrun   = overrun_q;

endmodule
